// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
// MULDIV_W_MASK exists only when MULDIV_WORD_OPS_EN is defined.
package muldiv_unit_pkg;

    typedef logic [63:0] dword_t;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } muldivop_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

`ifdef MULDIV_WORD_OPS_EN
    localparam dword_t MULDIV_W_MASK = 64'h0000_0000_FFFF_FFFF;
`endif

    // Maps a word op onto the full-width op that shares its arithmetic.
    function automatic muldivop_t full_width_op(input muldivop_t op);
        case (op)
            OP_MULW:  return OP_MUL;
            OP_DIVW:  return OP_DIV;
            OP_DIVUW: return OP_DIVU;
            OP_REMW:  return OP_REM;
            OP_REMUW: return OP_REMU;
            default:  return op;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One CALC iteration: RADIX_BITS of shift-add multiply or restoring division.
module muldiv_unit_step #(
    parameter int XLEN       = 64,
    parameter int RADIX_BITS = 1
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] opnd_i,
    input  logic [XLEN:0]   hi_i,
    input  logic [XLEN-1:0] lo_i,
    output logic [XLEN:0]   hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN+RADIX_BITS-1:0] m_sum;
    logic [XLEN:0]              d_rem;
    logic [XLEN-1:0]            d_quo;

    // Multiplier bits leave lo from the bottom while product bits enter from the top.
    always_comb begin
        m_sum = {{RADIX_BITS{1'b0}}, hi_i[XLEN-1:0]};
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (lo_i[i]) begin
                m_sum = m_sum + ({{RADIX_BITS{1'b0}}, opnd_i} << i);
            end
        end
    end

    always_comb begin
        d_rem = hi_i;
        d_quo = lo_i;
        for (int i = 0; i < RADIX_BITS; i++) begin
            d_rem = {d_rem[XLEN-1:0], d_quo[XLEN-1]};
            d_quo = {d_quo[XLEN-2:0], 1'b0};
            if (d_rem >= {1'b0, opnd_i}) begin
                d_rem    = d_rem - {1'b0, opnd_i};
                d_quo[0] = 1'b1;
            end
        end
    end

    always_comb begin
        hi_o = {1'b0, m_sum[XLEN+RADIX_BITS-1:RADIX_BITS]};
        lo_o = {m_sum[RADIX_BITS-1:0], lo_i[XLEN-1:RADIX_BITS]};
        if (div_i) begin
            hi_o = d_rem;
            lo_o = d_quo;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit with valid/ready handshake and flush.
// Define MULDIV_WORD_OPS_EN to give the *W ops true 32-bit semantics.
//   state | meaning
//   IDLE  | waiting for an operation, in_ready high
//   PREP  | operand magnitudes, result sign, special-case divides
//   CALC  | RADIX_BITS bits per cycle until the counter reaches zero
//   FIX   | sign correction and result selection
//   DONE  | result held until out_ready
import muldiv_unit_pkg::*;

module muldiv_unit #(
    parameter int XLEN       = 64,
    parameter int RADIX_BITS = 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] porta,
    input  logic [XLEN-1:0] portb,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int ITERS = XLEN / RADIX_BITS;
    localparam int CNT_W = $clog2(ITERS);

    muldiv_state_t state_q, state_d;
    muldivop_t     op_q, op_dec, op_base;
    logic [XLEN-1:0]  a_q, b_q, lo_q, result_q;
    logic [XLEN:0]    hi_q;
    logic [CNT_W-1:0] cnt_q;
    logic neg_q, in_ready_q, out_valid_q, busy_q;

    logic accept, is_div, is_rem, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   ea, eb, abs_a, abs_b, min_val, lo_init, fix_val;
    logic [CNT_W-1:0]  cnt_init;
    logic [XLEN:0]     step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

`ifdef MULDIV_WORD_OPS_EN
    logic word_op;
    assign op_dec  = muldivop_t'(op);
    assign word_op = (op_q != op_base);
`else
    assign op_dec  = full_width_op(muldivop_t'(op));
`endif
    assign op_base = full_width_op(op_q);
    assign accept  = (state_q == IDLE) && in_valid && in_ready_q && !flush;

    always_comb begin
        is_div = 1'b0;
        is_rem = 1'b0;
        sgn_a  = 1'b0;
        sgn_b  = 1'b0;
        case (op_base)
            OP_MULH:   begin sgn_a = 1'b1; sgn_b = 1'b1; end
            OP_MULHSU: sgn_a = 1'b1;
            OP_DIV:    begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            OP_REM:    begin is_div = 1'b1; is_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            OP_DIVU:   is_div = 1'b1;
            OP_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
            default:   ;
        endcase
    end

    always_comb begin
        ea       = a_q;
        eb       = b_q;
        min_val  = {1'b1, {(XLEN-1){1'b0}}};
        cnt_init = CNT_W'(ITERS - 1);
`ifdef MULDIV_WORD_OPS_EN
        // Word ops run on the extended low halves, and MIN/-1 is the 32-bit MIN.
        if (word_op) begin
            ea       = sgn_a ? XLEN'($signed(a_q[31:0])) : (a_q & MULDIV_W_MASK[XLEN-1:0]);
            eb       = sgn_b ? XLEN'($signed(b_q[31:0])) : (b_q & MULDIV_W_MASK[XLEN-1:0]);
            min_val  = XLEN'($signed(32'h8000_0000));
            cnt_init = CNT_W'(32 / RADIX_BITS - 1);
        end
`endif
    end

    always_comb begin
        a_neg    = sgn_a & ea[XLEN-1];
        b_neg    = sgn_b & eb[XLEN-1];
        abs_a    = a_neg ? -ea : ea;
        abs_b    = b_neg ? -eb : eb;
        div_zero = is_div && (eb == '0);
        div_ovf  = is_div && sgn_a && (ea == min_val) && (eb == '1);
        lo_init  = is_div ? abs_a : abs_b;
`ifdef MULDIV_WORD_OPS_EN
        // A 32-bit dividend must sit at the top so 32 steps consume all of it.
        if (word_op && is_div) begin
            lo_init = abs_a << (XLEN - 32);
        end
`endif
    end

    muldiv_unit_step #(
        .XLEN       (XLEN),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .div_i  (is_div),
        .opnd_i (is_div ? b_q : a_q),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        prod   = {hi_q[XLEN-1:0], lo_q};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo_q : lo_q;
        rem_s  = neg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
        case (op_base)
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_val = quo_s;
            OP_REM, OP_REMU:              fix_val = rem_s;
            default:                      fix_val = prod_s[XLEN-1:0];
        endcase
`ifdef MULDIV_WORD_OPS_EN
        if (word_op) begin
            case (op_base)
                OP_DIV, OP_DIVU: fix_val = XLEN'($signed(quo_s[31:0]));
                OP_REM, OP_REMU: fix_val = XLEN'($signed(rem_s[31:0]));
                default:         fix_val = XLEN'($signed(lo_q[XLEN-1 -: 32]));
            endcase
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready_q) state_d = PREP;
            PREP:    state_d = (div_zero || div_ovf) ? FIX : CALC;
            CALC:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= op_dec;
                        a_q  <= porta;
                        b_q  <= portb;
                    end
                end
                PREP: begin
                    a_q   <= abs_a;
                    b_q   <= abs_b;
                    cnt_q <= cnt_init;
                    if (div_zero || div_ovf) begin
                        // Raw answers placed where FIX expects quotient (lo) and remainder (hi).
                        neg_q <= 1'b0;
                        lo_q  <= div_ovf ? ea : '1;
                        hi_q  <= div_ovf ? '0 : {1'b0, ea};
                    end else begin
                        neg_q <= is_rem ? a_neg : (a_neg ^ b_neg);
                        lo_q  <= lo_init;
                        hi_q  <= '0;
                    end
                end
                CALC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    if (!flush) begin
                        result_q <= fix_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=64, RADIX_BITS=1.
import muldiv_unit_pkg::*;

module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [63:0] porta, portb, result;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(64), .RADIX_BITS(1)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .porta     (porta),
        .portb     (portb),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one operation, returns after the accept edge with operands scrambled.
    task automatic start(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        op       = o;
        porta    = a;
        portb    = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        porta    = ~a;
        portb    = ~b;
        op       = 4'(OP_MULHU);
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        start(o, a, b);
        wait_valid(lat);
        chk({tag, " result"}, result, exp);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        tick();
        chk({tag, " in_ready after handshake"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int  lat;
        logic bad;
        logic [63:0] held;

        nRST = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 4'd0; porta = '0; portb = '0;
        #12;
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset result", result, 64'd0);
        #2 nRST = 1'b1;
        tick();

        out_ready = 1'b1;
        start(4'(OP_MUL), 64'h7, 64'h6);
        chk("mul busy after accept", {63'd0, busy}, 64'd1);
        chk("mul in_ready after accept", {63'd0, in_ready}, 64'd0);
        wait_valid(lat);
        chk("mul 7x6 result", result, 64'h2A);
        chk("mul 7x6 latency", 64'(lat), 64'd67);
        tick();
        chk("mul in_ready after handshake", {63'd0, in_ready}, 64'd1);
        chk("mul out_valid after handshake", {63'd0, out_valid}, 64'd0);

        run("mulh -1x2",   4'(OP_MULH),   64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        run("mulhu -1x2",  4'(OP_MULHU),  64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, 67);
        run("mulhsu -1x2", 4'(OP_MULHSU), 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        run("mulh -1x-1",  4'(OP_MULH),   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 67);
        run("mulhu max",   4'(OP_MULHU),  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 67);
        run("mul max lo",  4'(OP_MUL),    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 67);
        run("div -7/2",    4'(OP_DIV),    64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
        run("rem -7/2",    4'(OP_REM),    64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        run("divu 100/7",  4'(OP_DIVU),   64'd100, 64'd7, 64'd14, 67);
        run("remu 100/7",  4'(OP_REMU),   64'd100, 64'd7, 64'd2, 67);
        run("divu 16/0",   4'(OP_DIVU),   64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run("remu 16/0",   4'(OP_REMU),   64'h10, 64'h0, 64'h10, 3);
        run("div -5/0",    4'(OP_DIV),    64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run("rem -5/0",    4'(OP_REM),    64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB, 3);
        run("div min/-1",  4'(OP_DIV),    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 3);
        run("rem min/-1",  4'(OP_REM),    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3);
        run("mulw 7x6",    4'(OP_MULW),   64'h7, 64'h6, 64'h2A, `ifdef MULDIV_WORD_OPS_EN 35 `else 67 `endif);
`ifdef MULDIV_WORD_OPS_EN
        run("divw overflow", 4'(OP_DIVW), 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 3);
        run("divuw 7/2",     4'(OP_DIVUW), 64'hAAAA_0000_0000_0007, 64'h5555_0000_0000_0002, 64'h3, 35);
`else
        run("divw as div",   4'(OP_DIVW), 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h1, 67);
        run("remw as rem",   4'(OP_REMW), 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h8000_0001, 67);
`endif

        // Flush in IDLE blocks an accept.
        op = 4'(OP_MUL); porta = 64'd3; portb = 64'd3;
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush blocks accept busy", {63'd0, busy}, 64'd0);

        // Flush during cycle 20 of a DIV.
        start(4'(OP_DIV), 64'd100, 64'd7);
        for (int i = 1; i < 20; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", {63'd0, busy}, 64'd0);
        chk("flush in_ready", {63'd0, in_ready}, 64'd1);
        bad = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) bad = 1'b1;
            tick();
        end
        chk("flush no out_valid", {63'd0, bad}, 64'd0);

        run("mul 3x3 after flush", 4'(OP_MUL), 64'd3, 64'd3, 64'd9, 67);

        // Consumer stalls in DONE.
        out_ready = 1'b0;
        start(4'(OP_DIVU), 64'd100, 64'd7);
        wait_valid(lat);
        chk("stall result", result, 64'd14);
        held = result;
        bad  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || in_ready || result !== held) bad = 1'b1;
        end
        chk("stall stable", {63'd0, bad}, 64'd0);
        out_ready = 1'b1;
        tick();
        chk("stall release out_valid", {63'd0, out_valid}, 64'd0);
        chk("stall release in_ready", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset in the middle of CALC.
        start(4'(OP_MUL), 64'd5, 64'd5);
        for (int i = 0; i < 10; i++) tick();
        #2 nRST = 1'b0;
        #1;
        chk("async reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("async reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("async reset busy", {63'd0, busy}, 64'd0);
        chk("async reset result", result, 64'd0);
        #1 nRST = 1'b1;
        tick();
        run("remu after reset", 4'(OP_REMU), 64'd100, 64'd7, 64'd2, 67);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative RV64M multiply/divide unit; the multi-cycle successor to the combinational ALU datapath.
- Sits in execute beside the ALU.
- Accepts one operation through a valid/ready handshake, iterates XLEN/RADIX_BITS cycles, then holds the result until the consumer accepts it.
- Supports signed/unsigned high/low multiply, divide and remainder, with a pipeline flush for mispredicts and traps.

Parameters:
- XLEN, 64, operand and result width; must be 32 or 64.
- RADIX_BITS, 1, bits retired per CALC cycle; must be 1, 2 or 4 and divide XLEN.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept an operation.
- op  input  4  muldivop_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
- porta  input  XLEN  rs1 operand, sampled on accept.
- portb  input  XLEN  rs2 operand, sampled on accept.
- flush  input  1  abort any in-flight operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  final result, stable while out_valid is high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0; result = 0.
  - All internal registers cleared.
- FSM states: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid && in_ready at the rising edge; latch op, porta and portb; go to PREP.
- PREP (1 cycle):
  - Take absolute values of the signed operands per op.
  - Record result sign: quotient sign = sa^sb; remainder sign = sa; MULH sign = sa^sb; MULHSU sign = sa.
  - Load iteration counter with XLEN/RADIX_BITS - 1.
  - Special cases jump straight to FIX:
    - divisor == 0: quotient = all ones; remainder = dividend.
    - signed overflow (dividend = MIN, divisor = -1): quotient = MIN; remainder = 0.
- CALC:
  - Multiply: shift-add, RADIX_BITS multiplier bits per cycle into a 2*XLEN accumulator.
  - Divide: restoring division, RADIX_BITS quotient bits per cycle.
  - Counter decrements each cycle; exit to FIX when counter == 0.
- FIX (1 cycle):
  - Apply sign correction (two's complement negate).
  - Select the low/high product, quotient or remainder.
  - Register the selection into result.
- DONE:
  - out_valid = 1; result held stable.
  - On out_valid && out_ready, go to IDLE. in_ready rises the following cycle; there is no accept in the DONE handshake cycle.
- Latency, accept edge to out_valid high:
  - Normal operations: XLEN/RADIX_BITS + 3 cycles (67 at defaults).
  - Special-case divides: 3 cycles.
- Flush:
  - Synchronous; overrides every other condition, including in_valid in IDLE.
  - Next state is IDLE; out_valid falls next cycle; the pending result is discarded.
  - Flush in the same cycle as out_ready: the result counts as not consumed.
- out_ready while out_valid is low is ignored.
- Operand changes after accept have no effect.
- Arithmetic:
  - All intermediates are XLEN+1 bits wide (divide) or 2*XLEN bits wide (multiply).
  - No wrap except the defined MIN/-1 case.
  - MULHSU: porta signed, portb unsigned.

Optional Feature:
- Macro: MULDIV_WORD_OPS_EN.
- Defined:
  - *W ops operate on the sign- or zero-extended low 32 bits per RV64M.
  - The 32-bit result is sign-extended to XLEN.
  - Iteration count is 32/RADIX_BITS, so latency is 35 at RADIX_BITS = 1.
  - Special cases are evaluated on 32-bit values.
- Undefined:
  - *W op encodings decode as their full-width counterparts (MULW -> MUL, DIVW -> DIV, and so on).
  - No extension logic is present.

Decomposition:
- types_pkg additions:
  - muldivop_t enum.
  - muldiv_state_t enum (IDLE, PREP, CALC, FIX, DONE).
  - MULDIV_W_MASK constant.
  - dword_t reused for XLEN = 64.
- Interface: muldiv_if with modports muldiv and tb, mirroring the ALU interface style.
- Sub-module: muldiv_step, a combinational single-iteration step (RADIX_BITS-wide add/subtract and shift), instantiated inside CALC.

Test Plan:
- MUL 0x7 x 0x6, out_ready held high -> result 0x2A; out_valid at cycle 67; in_ready high the cycle after the handshake.
- MULH 0xFFFFFFFFFFFFFFFF x 0x2 -> 0xFFFFFFFFFFFFFFFF.
- MULHU with the same operands -> 0x1.
- DIV -7 / 2 -> 0xFFFFFFFFFFFFFFFD.
- REM -7 / 2 -> 0xFFFFFFFFFFFFFFFF.
- DIVU 0x10 / 0 -> all ones, latency 3.
- REMU 0x10 / 0 -> 0x10.
- DIV 0x8000000000000000 / -1 -> 0x8000000000000000, latency 3.
- REM with the same operands -> 0.
- Flush asserted at cycle 20 of DIV -> IDLE next cycle, no out_valid.
- New MUL 3 x 3 accepted next -> 0x9.
- out_ready low for 10 cycles in DONE -> out_valid and result stable, in_ready low; handshake then returns to IDLE.
- nRST pulsed mid-CALC -> all outputs at reset values immediately.
- With MULDIV_WORD_OPS_EN: DIVW 0x0000000180000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000.
